// File: rtl/note_stack_decoder.sv
// PS/2 scancode decoder: prefix FSM, shift-resolved sharps, last-note-priority stack and
// keyboard-stepped octave, driving the tone generator's note/octave/gate and event strobes.
module note_stack_decoder #(
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned OCT_MIN     = 0,
    parameter int unsigned OCT_MAX     = 7,
    parameter int unsigned OCT_RESET   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic       gate,
    output logic       note_change,
    output logic       overflow
);

    localparam int unsigned CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0] OCT_LO = 3'(OCT_MIN);
    localparam logic [2:0] OCT_HI = 3'(OCT_MAX);

    typedef enum logic [1:0] {StIdle, StBrk, StExt, StExtBrk} state_e;
    typedef enum logic [2:0] {KNone, KNote, KShiftL, KShiftR, KOctDn, KOctUp} kind_e;

    typedef struct packed {
        logic [2:0] key;
        logic [3:0] note;
    } entry_t;

    // Key ids: C=0 D=1 E=2 F=3 G=4 A=5 B=6; a sharp is one index below its natural.
    function automatic logic [3:0] resolve_note(input logic [2:0] key, input logic sharp);
        logic [3:0] nat;
        case (key)
            3'd0:    nat = 4'd12;
            3'd1:    nat = 4'd10;
            3'd2:    nat = 4'd8;
            3'd3:    nat = 4'd7;
            3'd4:    nat = 4'd5;
            3'd5:    nat = 4'd3;
            default: nat = 4'd1;
        endcase
        if (sharp && key != 3'd2 && key != 3'd6) begin
            return nat - 4'd1;
        end
        return nat;
    endfunction

    state_e                   state_q, state_d;
    entry_t [STACK_DEPTH-1:0] stack_q, stack_d;
    logic   [CNT_W-1:0]       count_q, count_d;
    logic   [2:0]             oct_q, oct_d;
    logic                     shift_l_q, shift_l_d;
    logic                     shift_r_q, shift_r_d;
    logic                     change_q, change_d;
    logic                     ovf_q, ovf_d;

    kind_e            kind;
    logic [2:0]       key_id;
    logic             is_make;
    logic             is_break;
    logic             hit;
    logic [CNT_W-1:0] hit_idx;
    logic [3:0]       new_note;
    logic [3:0]       cur_note;
    logic [3:0]       nxt_note;

    always_comb begin
        kind   = KNone;
        key_id = 3'd0;
        case (scan_code)
            8'h21:   begin kind = KNote; key_id = 3'd0; end
            8'h23:   begin kind = KNote; key_id = 3'd1; end
            8'h24:   begin kind = KNote; key_id = 3'd2; end
            8'h2B:   begin kind = KNote; key_id = 3'd3; end
            8'h34:   begin kind = KNote; key_id = 3'd4; end
            8'h1C:   begin kind = KNote; key_id = 3'd5; end
            8'h32:   begin kind = KNote; key_id = 3'd6; end
            8'h12:   kind = KShiftL;
            8'h59:   kind = KShiftR;
            8'h1A:   kind = KOctDn;
            8'h22:   kind = KOctUp;
            default: kind = KNone;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        is_make  = 1'b0;
        is_break = 1'b0;
        if (scan_valid) begin
            case (state_q)
                StIdle: begin
                    if (scan_code == 8'hF0) begin
                        state_d = StBrk;
                    end else if (scan_code == 8'hE0) begin
                        state_d = StExt;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                StBrk: begin
                    is_break = 1'b1;
                    state_d  = StIdle;
                end
                StExt:   state_d = (scan_code == 8'hF0) ? StExtBrk : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Keys on the stack are unique, so the first match is the only one.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (!hit && CNT_W'(i) < count_q && stack_q[i].key == key_id) begin
                hit     = 1'b1;
                hit_idx = CNT_W'(i);
            end
        end
    end

    assign new_note = resolve_note(key_id, shift_l_q | shift_r_q);

    always_comb begin
        stack_d   = stack_q;
        count_d   = count_q;
        oct_d     = oct_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        ovf_d     = 1'b0;
        if (is_make) begin
            case (kind)
                KNote: begin
                    if (!hit) begin
                        if (count_q == CNT_FULL) begin
                            for (int unsigned i = 0; i < STACK_DEPTH - 1; i++) begin
                                stack_d[i] = stack_q[i + 1];
                            end
                            stack_d[STACK_DEPTH-1].key  = key_id;
                            stack_d[STACK_DEPTH-1].note = new_note;
                            ovf_d = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                                if (CNT_W'(i) == count_q) begin
                                    stack_d[i].key  = key_id;
                                    stack_d[i].note = new_note;
                                end
                            end
                            count_d = count_q + CNT_ONE;
                        end
                    end
                end
                KShiftL: shift_l_d = 1'b1;
                KShiftR: shift_r_d = 1'b1;
                KOctDn:  if (oct_q != OCT_LO) oct_d = oct_q - 3'd1;
                KOctUp:  if (oct_q != OCT_HI) oct_d = oct_q + 3'd1;
                default: ;
            endcase
        end else if (is_break) begin
            case (kind)
                KNote: begin
                    if (hit) begin
                        // Close the gap left by the released key, preserving order.
                        for (int unsigned i = 0; i < STACK_DEPTH - 1; i++) begin
                            if (CNT_W'(i) >= hit_idx) begin
                                stack_d[i] = stack_q[i + 1];
                            end
                        end
                        stack_d[STACK_DEPTH-1] = '0;
                        count_d = count_q - CNT_ONE;
                    end
                end
                KShiftL: shift_l_d = 1'b0;
                KShiftR: shift_r_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        cur_note = 4'd0;
        nxt_note = 4'd0;
        for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
            if (CNT_W'(i + 1) == count_q) cur_note = stack_q[i].note;
            if (CNT_W'(i + 1) == count_d) nxt_note = stack_d[i].note;
        end
        change_d = {nxt_note, oct_d} != {cur_note, oct_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            stack_q   <= '0;
            count_q   <= '0;
            oct_q     <= 3'(OCT_RESET);
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
            change_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            stack_q   <= stack_d;
            count_q   <= count_d;
            oct_q     <= oct_d;
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
            change_q  <= change_d;
            ovf_q     <= ovf_d;
        end
    end

    assign note        = cur_note;
    assign octave      = oct_q;
    assign gate        = count_q != '0;
    assign note_change = change_q;
    assign overflow    = ovf_q;

endmodule

// File: doc/note_stack_decoder.md
# note_stack_decoder

Parametrised successor to the single-note keyboard decoder. It consumes the PS/2 scancode byte stream, including make, break (0xF0) and extended (0xE0) sequences, and tracks held shift keys. Held notes go on a last-note-priority stack, and an octave register is stepped from the keyboard. Outputs are the audio controller's note index (same 0–12 encoding as the existing tone path), the octave, a gate, and change/overflow strobes for the tone generator.

## Interface
- STACK_DEPTH, 4, number of simultaneously held notes remembered (2–8)
- OCT_MIN, 0, lowest octave value
- OCT_MAX, 7, highest octave value (≤ 7)
- OCT_RESET, 4, octave after reset (OCT_MIN ≤ OCT_RESET ≤ OCT_MAX)

- clk  in  1  system clock (50 MHz)
- rst  in  1  reset; asynchronous, active-high
- scan_code  in  8  received PS/2 byte
- scan_valid  in  1  one-cycle strobe, scan_code valid; may be high on consecutive cycles
- note  out  4  top-of-stack note index, 0 = none
- octave  out  3  current octave
- gate  out  1  high while stack non-empty
- note_change  out  1  one-cycle pulse when {note, octave} changes
- overflow  out  1  one-cycle pulse when a push evicts the oldest entry

## Operation
- Note encoding: 0 none, 1 B, 2 A#, 3 A, 4 G#, 5 G, 6 F#, 7 F, 8 E, 9 D#, 10 D, 11 C#, 12 C.
- Note keys: C 0x21, D 0x23, E 0x24, F 0x2B, G 0x34, A 0x1C, B 0x32.
- Shift keys: left 0x12, right 0x59. shift_held = left OR right, tracked from the make and break of each shift key.
- Octave keys: Z 0x1A (down), X 0x22 (up). These act on make only and saturate at OCT_MIN/OCT_MAX.
- Prefix FSM states: IDLE, BRK (after 0xF0), EXT (after 0xE0), EXT_BRK (after 0xE0 0xF0).
  - IDLE: 0xF0 → BRK; 0xE0 → EXT; any other byte is processed as a make, stay IDLE.
  - BRK: the byte is processed as a break → IDLE.
  - EXT: 0xF0 → EXT_BRK; any other byte is discarded → IDLE.
  - EXT_BRK: the byte is discarded → IDLE.
- Note make: the note is resolved at press time.
  - With shift_held, C/D/F/G/A give the sharp.
  - With shift_held, E and B give the natural.
- Stack entries store {key id 3 b, resolved note 4 b}.
- Make of a key already on the stack (typematic repeat): no change.
- Make of a new key: push on top. If the stack is full, drop the bottom entry and pulse overflow.
- Note break: remove the entry with a matching key id from any position, compact in one cycle, and keep the order of the remaining entries. A break for a key not on the stack is ignored.
- A shift break clears only its own flag. Stored notes keep their resolved value.
- Unknown scancodes (make or break) are ignored.
- Outputs:
  - note = top entry's note, or 0 when the stack is empty.
  - gate = stack non-empty.
  - note_change is high for the cycle in which a new {note, octave} value first appears.
  - Octave saturation or a repeat that leaves {note, octave} unchanged produces no pulse.

## Timing
- A byte sampled at edge N (scan_valid=1) takes effect at edge N; note, octave, gate and the pulses are valid after edge N (1-cycle latency from strobe).
- Back-to-back bytes are all processed. No byte is dropped regardless of strobe spacing.
- Reset values:
  - note 0, octave OCT_RESET, gate 0, note_change 0, overflow 0.
  - Stack empty, shift flags 0, FSM IDLE.
- Reset mid-sequence (e.g. after 0xF0) discards the prefix. The next byte is treated as a make.
- When a push and an eviction happen together, overflow and note_change pulse in the same cycle.

## Test plan
- Reset: assert rst → note 0, octave 4, gate 0, no pulses. Release, send nothing → outputs hold.
- Make/break:
  - 0x21 → note 12, gate 1, note_change for 1 cycle.
  - 0xF0 0x21 → note 0, gate 0, note_change for 1 cycle.
- Shift:
  - 0x12, then 0x1C → note 2.
  - 0xF0 0x12, then 0x23 → note 10.
  - 0xF0 0x1C → note stays 10.
  - Repeat 0x23 → no pulse.
- Stack (DEPTH 4):
  - Press C, D, E, F, G → overflow pulses on G, note 5.
  - Release G → 7.
  - Release F, E, D → note 0, gate 0 (C was evicted).
- Octave:
  - 0x22 ×4 from 4 → 5, 6, 7, 7; the fourth press gives no pulse.
  - 0x1A ×8 → saturates at 0.
  - With C held, each change pulses note_change.
- Prefixes/reset:
  - C held, then 0xE0 0xF0 0x21 → note stays 12.
  - rst after 0xF0, then 0x21 → note 12 (make).
